// File: rtl/pixel_filter_pkg.sv
// pixel_filter_pkg
//   Shared types and constants for the pixel filter pipeline:
//   - mode_e      : latched filter mode (gray / pink / pass / invert)
//   - weights     : gray and pink channel weights and scale shifts
//   - gain caps   : latched tint gain is clamped to [GAIN_MIN, GAIN_MAX]
//   - decode_sel  : maps the 3-bit filter_sel request onto mode_e
//   Optional feature macro: PIXEL_FILTER_INVERT_EN (sel 4 -> invert mode).
package pixel_filter_pkg;

    typedef enum logic [1:0] {
        MODE_GRAY = 2'd0,
        MODE_PINK = 2'd1,
        MODE_PASS = 2'd2,
        MODE_INV  = 2'd3
    } mode_e;

    localparam int unsigned GRAY_WR    = 77;
    localparam int unsigned GRAY_WG    = 150;
    localparam int unsigned GRAY_WB    = 29;
    localparam int unsigned GRAY_SHIFT = 8;

    localparam int unsigned PINK_WR         = 120;
    localparam int unsigned PINK_WG         = 60;
    localparam int unsigned PINK_WB         = 50;
    localparam int unsigned PINK_GAIN_SHIFT = 6;
    localparam int unsigned PINK_SHIFT      = 8;

    localparam int unsigned GAIN_MIN  = 10;
    localparam int unsigned GAIN_MAX  = 63;
    localparam int unsigned GAIN_BITS = 6;

    // Weighted sums are below 256 * channel max, so 8 guard bits suffice.
    localparam int unsigned SUM_GUARD = 8;

    function automatic mode_e decode_sel(input logic [2:0] sel);
        mode_e m;
        case (sel)
            3'd0, 3'd2: m = MODE_GRAY;
            3'd1:       m = MODE_PINK;
`ifdef PIXEL_FILTER_INVERT_EN
            3'd4:       m = MODE_INV;
`endif
            default:    m = MODE_PASS;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pixel_filter_math.sv
// pixel_filter_math
//   Combinational S2 arithmetic of the pixel filter pipeline.
//   Ports:
//     r_i, g_i, b_i : expanded colour channels (OUT_W bits each)
//     gain_i        : latched, capped tint gain
//     gray_o        : (77R+150G+29B)>>8
//     pink_prod_o   : (120R+60G+50B)*gain, unscaled, full width
module pixel_filter_math
    import pixel_filter_pkg::*;
#(
    parameter int unsigned OUT_W  = 10,
    parameter int unsigned PROD_W = OUT_W + SUM_GUARD + GAIN_BITS
) (
    input  logic [OUT_W-1:0]     r_i,
    input  logic [OUT_W-1:0]     g_i,
    input  logic [OUT_W-1:0]     b_i,
    input  logic [GAIN_BITS-1:0] gain_i,
    output logic [OUT_W-1:0]     gray_o,
    output logic [PROD_W-1:0]    pink_prod_o
);

    localparam int unsigned SUM_W = OUT_W + SUM_GUARD;

    logic [SUM_W-1:0] gray_sum;
    logic [SUM_W-1:0] pink_sum;

    always_comb begin
        gray_sum = SUM_W'(GRAY_WR) * SUM_W'(r_i)
                 + SUM_W'(GRAY_WG) * SUM_W'(g_i)
                 + SUM_W'(GRAY_WB) * SUM_W'(b_i);
        pink_sum = SUM_W'(PINK_WR) * SUM_W'(r_i)
                 + SUM_W'(PINK_WG) * SUM_W'(g_i)
                 + SUM_W'(PINK_WB) * SUM_W'(b_i);
        // Gray weights sum to 256, so the shifted result always fits OUT_W.
        gray_o      = OUT_W'(gray_sum >> GRAY_SHIFT);
        pink_prod_o = PROD_W'(pink_sum) * PROD_W'(gain_i);
    end

endmodule

// File: rtl/pixel_filter_pipe.sv
// pixel_filter_pipe
//   3-stage valid/ready colour filter: S1 expand, S2 weighted sums/gain,
//   S3 scale/saturate/select into the output register. One global stall:
//   every stage advances only when in_ready is high.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     filter_sel, pitch     : mode request and tint gain, latched on sof beats
//     in_valid/in_ready     : input handshake; in_sof, in_pixel {R,G,B}
//     out_valid/out_ready   : output handshake; out_sof, out_pixel {R,G,B}
//   Optional feature macro: PIXEL_FILTER_INVERT_EN (sel 4 inverts channels).
module pixel_filter_pipe
    import pixel_filter_pkg::*;
#(
    parameter int unsigned IN_W   = 4,
    parameter int unsigned OUT_W  = 10,
    parameter int unsigned GAIN_W = 30
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           filter_sel,
    input  logic [GAIN_W-1:0]    pitch,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sof,
    input  logic [3*IN_W-1:0]    in_pixel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sof,
    output logic [3*OUT_W-1:0]   out_pixel
);

    localparam int unsigned PROD_W      = OUT_W + SUM_GUARD + GAIN_BITS;
    localparam int unsigned PINK_SCALE  = PINK_GAIN_SHIFT + PINK_SHIFT;
    localparam logic [OUT_W-1:0] CH_MAX = '1;

    function automatic logic [OUT_W-1:0] expand(input logic [IN_W-1:0] c);
        logic [2*IN_W+OUT_W-1:0] t;
        t = {c, c, {OUT_W{1'b0}}};
        return t[2*IN_W+OUT_W-1 -: OUT_W];
    endfunction

    // ---------------- handshake / stall ----------------
    logic rdy_en_q;
    logic advance;
    logic accept;

    // rdy_en_q keeps in_ready low until the first edge after reset release.
    assign in_ready = rdy_en_q && (!out_valid || out_ready);
    assign advance  = in_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en_q <= 1'b0;
        else        rdy_en_q <= 1'b1;
    end

    // ---------------- latched mode / gain ----------------
    mode_e                 mode_q, mode_d;
    logic [GAIN_BITS-1:0]  gain_q, gain_d;
    mode_e                 sel_mode;
    logic [GAIN_BITS-1:0]  gain_capped;

    always_comb begin
        sel_mode = decode_sel(filter_sel);
        if (pitch < GAIN_W'(GAIN_MIN))      gain_capped = GAIN_BITS'(GAIN_MIN);
        else if (pitch > GAIN_W'(GAIN_MAX)) gain_capped = GAIN_BITS'(GAIN_MAX);
        else                                gain_capped = GAIN_BITS'(pitch);
        mode_d = mode_q;
        gain_d = gain_q;
        if (accept && in_sof) begin
            mode_d = sel_mode;
            gain_d = gain_capped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_GRAY;
            gain_q <= GAIN_BITS'(GAIN_MIN);
        end else begin
            mode_q <= mode_d;
            gain_q <= gain_d;
        end
    end

    // ---------------- S1: expand ----------------
    logic                 s1_valid_q, s1_sof_q;
    mode_e                s1_mode_q, s1_mode_d;
    logic [GAIN_BITS-1:0] s1_gain_q, s1_gain_d;
    logic [OUT_W-1:0]     s1_r_q, s1_g_q, s1_b_q;

    // A sof beat already uses the values it latches.
    always_comb begin
        s1_mode_d = in_sof ? sel_mode : mode_q;
        s1_gain_d = in_sof ? gain_capped : gain_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_mode_q  <= MODE_GRAY;
            s1_gain_q  <= '0;
            s1_r_q     <= '0;
            s1_g_q     <= '0;
            s1_b_q     <= '0;
        end else if (advance) begin
            s1_valid_q <= in_valid;
            s1_sof_q   <= in_sof;
            s1_mode_q  <= s1_mode_d;
            s1_gain_q  <= s1_gain_d;
            s1_r_q     <= expand(in_pixel[3*IN_W-1 -: IN_W]);
            s1_g_q     <= expand(in_pixel[2*IN_W-1 -: IN_W]);
            s1_b_q     <= expand(in_pixel[IN_W-1:0]);
        end
    end

    // ---------------- S2: weighted sums / gain ----------------
    logic [OUT_W-1:0]  gray_w;
    logic [PROD_W-1:0] prod_w;

    pixel_filter_math #(
        .OUT_W  (OUT_W),
        .PROD_W (PROD_W)
    ) u_math (
        .r_i         (s1_r_q),
        .g_i         (s1_g_q),
        .b_i         (s1_b_q),
        .gain_i      (s1_gain_q),
        .gray_o      (gray_w),
        .pink_prod_o (prod_w)
    );

    logic              s2_valid_q, s2_sof_q;
    mode_e             s2_mode_q;
    logic [OUT_W-1:0]  s2_r_q, s2_g_q, s2_b_q, s2_gray_q;
    logic [PROD_W-1:0] s2_prod_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_sof_q   <= 1'b0;
            s2_mode_q  <= MODE_GRAY;
            s2_r_q     <= '0;
            s2_g_q     <= '0;
            s2_b_q     <= '0;
            s2_gray_q  <= '0;
            s2_prod_q  <= '0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            s2_sof_q   <= s1_sof_q;
            s2_mode_q  <= s1_mode_q;
            s2_r_q     <= s1_r_q;
            s2_g_q     <= s1_g_q;
            s2_b_q     <= s1_b_q;
            s2_gray_q  <= gray_w;
            s2_prod_q  <= prod_w;
        end
    end

    // ---------------- S3: scale / saturate / select ----------------
    logic [PROD_W-1:0]  pink_s;
    logic [OUT_W-1:0]   pink_r;
    logic [3*OUT_W-1:0] px_d;

    always_comb begin
        pink_s = s2_prod_q >> PINK_SCALE;
        pink_r = (pink_s > PROD_W'(CH_MAX)) ? CH_MAX : pink_s[OUT_W-1:0];
        case (s2_mode_q)
            MODE_GRAY: px_d = {3{s2_gray_q}};
            MODE_PINK: px_d = {pink_r, pink_r >> 2, pink_r >> 1};
`ifdef PIXEL_FILTER_INVERT_EN
            // Max minus value is the bitwise complement for an all-ones max.
            MODE_INV:  px_d = ~{s2_r_q, s2_g_q, s2_b_q};
`endif
            default:   px_d = {s2_r_q, s2_g_q, s2_b_q};
        endcase
    end

    logic               out_valid_q, out_sof_q;
    logic [3*OUT_W-1:0] out_pixel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_pixel_q <= '0;
        end else if (advance) begin
            out_valid_q <= s2_valid_q;
            out_sof_q   <= s2_sof_q;
            out_pixel_q <= px_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_pixel = out_pixel_q;

endmodule

// File: tb/tb_pixel_filter_pipe.sv
// tb_pixel_filter_pipe
//   Directed vectors, stall/mode/reset sequences and a randomized phase,
//   all compared against an arithmetic reference model with a scoreboard.
//   Honours PIXEL_FILTER_INVERT_EN for the sel 4 expectations.
module tb_pixel_filter_pipe;

    localparam int IN_W   = 4;
    localparam int OUT_W  = 10;
    localparam int GAIN_W = 30;
    localparam int PW     = 3 * OUT_W;
    localparam longint CMAX = (64'd1 << OUT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        filter_sel;
    logic [GAIN_W-1:0] pitch;
    logic              in_valid, in_ready, in_sof;
    logic [3*IN_W-1:0] in_pixel;
    logic              out_valid, out_ready, out_sof;
    logic [PW-1:0]     out_pixel;

    always #5 clk = ~clk;

    pixel_filter_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .filter_sel (filter_sel),
        .pitch      (pitch),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sof     (in_sof),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sof    (out_sof),
        .out_pixel  (out_pixel)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint expand_m(input longint c);
        return ((c * (64'd1 << IN_W) + c) * (64'd1 << OUT_W)) / (64'd1 << (2 * IN_W));
    endfunction

    function automatic int clamp_gain(input longint p);
        if (p < 10) return 10;
        if (p > 63) return 63;
        return int'(p);
    endfunction

    function automatic logic [PW-1:0] model_px(input int sel, input int gain, input logic [3*IN_W-1:0] px);
        longint r, g, b, y, s;
        logic [OUT_W-1:0] ro, go, bo;
        r = expand_m(longint'(px[11:8]));
        g = expand_m(longint'(px[7:4]));
        b = expand_m(longint'(px[3:0]));
        ro = OUT_W'(r); go = OUT_W'(g); bo = OUT_W'(b);
        if (sel == 0 || sel == 2) begin
            y = (77 * r + 150 * g + 29 * b) / 256;
            ro = OUT_W'(y); go = OUT_W'(y); bo = OUT_W'(y);
        end else if (sel == 1) begin
            s = ((120 * r + 60 * g + 50 * b) * gain) / 64 / 256;
            if (s > CMAX) s = CMAX;
            ro = OUT_W'(s); go = OUT_W'(s / 4); bo = OUT_W'(s / 2);
        end
`ifdef PIXEL_FILTER_INVERT_EN
        else if (sel == 4) begin
            ro = OUT_W'(CMAX - r); go = OUT_W'(CMAX - g); bo = OUT_W'(CMAX - b);
        end
`endif
        return {ro, go, bo};
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic [PW:0]   exp_q[$];
    logic [PW-1:0] out_log[$];
    int            m_sel = 0;
    int            m_gain = 10;
    int            n_out = 0;
    logic          prev_stall = 1'b0;
    logic [PW-1:0] prev_px;
    logic          prev_sof;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_sel = 0;
            m_gain = 10;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_pixel", longint'(out_pixel), longint'(prev_px));
                check("stall_hold_sof", longint'(out_sof), longint'(prev_sof));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", 1, 0);
                end else begin
                    logic [PW:0] e;
                    e = exp_q.pop_front();
                    check("sb_pixel", longint'(out_pixel), longint'(e[PW-1:0]));
                    check("sb_sof", longint'(out_sof), longint'(e[PW]));
                end
                out_log.push_back(out_pixel);
                n_out++;
            end
            if (in_valid && in_ready) begin
                if (in_sof) begin
                    m_sel = int'(filter_sel);
                    m_gain = clamp_gain(longint'(pitch));
                end
                exp_q.push_back({in_sof, model_px(m_sel, m_gain, in_pixel)});
            end
            prev_stall = out_valid && !out_ready;
            prev_px = out_pixel;
            prev_sof = out_sof;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sof, input int sel, input longint p, input logic [11:0] px);
        in_valid = v;
        in_sof = sof;
        filter_sel = 3'(sel);
        pitch = GAIN_W'(p);
        in_pixel = px;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) tick();
        check("drain_empty", longint'(exp_q.size()), 0);
    endtask

    typedef struct {
        string       name;
        int          sel;
        longint      pitch;
        logic [11:0] px;
        int          er, eg, eb;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timed out");
    end

    initial begin
        vec_t vecs[8];
        logic [PW-1:0] hold;
        logic [11:0] beats[5];
        int k, lat, idx, n0;
        logic acc;

        vecs[0] = '{"gray_fff",       0, 0,            12'hFFF, 1020, 1020, 1020};
        vecs[1] = '{"pink_fff_p100",  1, 100,          12'hFFF, 902, 225, 451};
        vecs[2] = '{"pink_fff_p5",    1, 5,            12'hFFF, 143, 35, 71};
        vecs[3] = '{"pass_a53",       3, 0,            12'hA53, 680, 340, 204};
`ifdef PIXEL_FILTER_INVERT_EN
        vecs[4] = '{"sel4_a53",       4, 0,            12'hA53, 343, 683, 819};
`else
        vecs[4] = '{"sel4_a53",       4, 0,            12'hA53, 680, 340, 204};
`endif
        vecs[5] = '{"gray2_a53",      2, 0,            12'hA53, 426, 426, 426};
        vecs[6] = '{"pink_zero",      1, 63,           12'h000, 0, 0, 0};
        vecs[7] = '{"pink_huge_gain", 1, 64'h3FFFFFFF, 12'hFFF, 902, 225, 451};

        // ---- reset ----
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 0, 0, 12'h000);
        repeat (2) tick();
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_sof", longint'(out_sof), 0);
        check("rst_out_pixel", longint'(out_pixel), 0);
        rst_n = 1'b1;
        check("rst_in_ready_low", longint'(in_ready), 0);
        tick();
        check("rst_in_ready_high", longint'(in_ready), 1);

        // ---- table vectors ----
        foreach (vecs[i]) begin
            drain();
            drive(1'b1, 1'b1, vecs[i].sel, vecs[i].pitch, vecs[i].px);
            check({vecs[i].name, "_in_ready"}, longint'(in_ready), 1);
            tick();
            in_valid = 1'b0;
            in_sof = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            check({vecs[i].name, "_latency"}, lat, 3);
            check({vecs[i].name, "_R"}, longint'(out_pixel[29:20]), vecs[i].er);
            check({vecs[i].name, "_G"}, longint'(out_pixel[19:10]), vecs[i].eg);
            check({vecs[i].name, "_B"}, longint'(out_pixel[9:0]), vecs[i].eb);
            check({vecs[i].name, "_sof"}, longint'(out_sof), 1);
        end

        // ---- stall: 5 beats offered with out_ready low ----
        drain();
        for (int i = 0; i < 5; i++) beats[i] = 12'($urandom);
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, k == 0, 1, 40, beats[k]);
            acc = in_ready;
            tick();
            if (acc) k++;
        end
        check("stall_accepted", k, 3);
        check("stall_in_ready", longint'(in_ready), 0);
        check("stall_out_valid", longint'(out_valid), 1);
        hold = out_pixel;
        n0 = n_out;
        repeat (3) tick();
        check("stall_pixel_stable", longint'(out_pixel), longint'(hold));
        out_ready = 1'b1;
        for (int c = 0; c < 10 && k < 5; c++) begin
            drive(1'b1, 1'b0, 1, 40, beats[k]);
            acc = in_ready;
            tick();
            if (acc) k++;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20 && n_out < n0 + 5; c++) tick();
        check("stall_release_count", n_out - n0, 5);
        drain();

        // ---- mode change mid-frame ----
        idx = out_log.size();
        drive(1'b1, 1'b1, 0, 0, 12'hA53);   tick();
        drive(1'b1, 1'b0, 1, 100, 12'hA53); tick();
        drive(1'b1, 1'b1, 1, 100, 12'hA53); tick();
        drive(1'b1, 1'b0, 0, 0, 12'hA53);   tick();
        drain();
        check("mode_count", out_log.size() - idx, 4);
        if (out_log.size() >= idx + 4) begin
            check("mode_sof_gray", longint'(out_log[idx]), longint'({10'd426, 10'd426, 10'd426}));
            check("mode_midframe_gray", longint'(out_log[idx+1]), longint'({10'd426, 10'd426, 10'd426}));
            check("mode_sof_pink", longint'(out_log[idx+2]), longint'({10'd431, 10'd107, 10'd215}));
            check("mode_midframe_pink", longint'(out_log[idx+3]), longint'({10'd431, 10'd107, 10'd215}));
        end

        // ---- randomized traffic ----
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 7)), longint'($urandom_range(0, 80)), 12'($urandom));
            out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        drain();

        // ---- reset with a full pipe ----
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, c == 0, 1, 100, 12'hFFF);
            tick();
        end
        in_valid = 1'b0;
        check("full_before_reset", longint'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_out_sof", longint'(out_sof), 0);
        check("midrst_out_pixel", longint'(out_pixel), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_in_ready", longint'(in_ready), 1);
        out_ready = 1'b1;
        idx = out_log.size();
        drive(1'b1, 1'b0, 1, 100, 12'hA53);
        tick();
        drain();
        check("midrst_out_count", out_log.size() - idx, 1);
        if (out_log.size() > idx)
            check("midrst_mode_gray", longint'(out_log[idx]), longint'({10'd426, 10'd426, 10'd426}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_filter_pipe.md
PIXEL_FILTER_PIPE -- requirements
Module: pixel_filter_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 4, input bits per colour channel.
REQ-002 SHALL have parameter OUT_W, default 10, output bits per colour channel (OUT_W >= IN_W+2).
REQ-003 SHALL have parameter GAIN_W, default 30, width of pitch input.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port filter_sel, input, 3, requested mode.
REQ-007 SHALL have port pitch, input, GAIN_W, unsigned tint gain.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_sof (input, 1, first pixel of frame), in_pixel (input, 3*IN_W, {R,G,B}).
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_sof (output, 1), out_pixel (output, 3*OUT_W, {R,G,B}).

Function
REQ-010 SHALL be a 3-stage pipeline: S1 expand, S2 weighted sums/gain, S3 scale/select/register.
REQ-011 SHALL transfer a beat when valid and ready are both high on a clock edge, on either side.
REQ-012 SHALL give latency 3 cycles from input acceptance to out_valid with out_ready held high; throughput 1 pixel/cycle.
REQ-013 SHALL drive in_ready = !S3_valid || out_ready (global stall); all stage registers hold while stalled.
REQ-014 SHALL hold out_pixel/out_sof stable while out_valid && !out_ready.
REQ-015 SHALL pass in_sof alongside its pixel to out_sof.
REQ-016 SHALL latch filter_sel and pitch only on an accepted beat with in_sof=1; that beat and all following use the latched values.
REQ-017 SHALL cap latched gain to range [10,63].
REQ-018 SHALL expand each channel c to OUT_W bits as {c,c} followed by zeros (IN_W=4: {c,c,2'b00}).
REQ-019 SHALL compute gray mode (sel 0,2) as Y = (77R+150G+29B)>>8 on all three channels.
REQ-020 SHALL compute pink mode (sel 1) as P=(120R+60G+50B), S=((P*gain)>>6)>>8, red=S saturated to 2^OUT_W-1, green=red>>2, blue=red>>1.
REQ-021 SHALL make pass-through mode (sel 3,5,6,7) output the expanded channels unchanged.
REQ-022 SHALL size intermediates so no product overflows before saturation.

Reset
REQ-023 SHALL clear all stage valids, out_valid, out_sof, out_pixel to 0 on rst_n low.
REQ-024 SHALL reset latched mode to gray and gain to 10.
REQ-025 SHALL drive in_ready 1 one cycle after rst_n deasserts; beats in flight at reset are discarded.

Configuration
REQ-026 SHALL, with PIXEL_FILTER_INVERT_EN defined, make sel 4 output (2^OUT_W-1) minus each expanded channel.
REQ-027 SHALL, without PIXEL_FILTER_INVERT_EN, treat sel 4 as pass-through with no invert logic synthesised.

Structure
REQ-028 SHALL place mode enum, gray/pink weights, gain caps 10/63 in package pixel_filter_pkg.
REQ-029 SHALL implement the S2 arithmetic in sub-module pixel_filter_math.

Verification
REQ-030 SHALL cover: sof beat sel=0, pixel 0xFFF -> after 3 cycles out_pixel R=G=B=1020, out_sof=1.
REQ-031 SHALL cover: sof sel=1, pitch=100, pixel 0xFFF -> R=902, G=225, B=451; same with pitch=5 -> R=143, G=35, B=71.
REQ-032 SHALL cover: sof sel=3, pixel 0xA53 -> R=680, G=340, B=204; with macro, sel=4 -> R=343, G=683, B=819.
REQ-033 SHALL cover: out_ready low, 5 beats offered -> exactly 3 accepted, in_ready low, output stable; release -> 5 beats out in order, none lost/duplicated.
REQ-034 SHALL cover: filter_sel changed mid-frame (non-sof) -> mode unchanged until next accepted sof beat.
REQ-035 SHALL cover: rst_n low mid-stream with full pipe -> out_valid 0 immediately, mode gray after release.
